// File: rtl/xor_stream_checksum.sv
// xor_stream_checksum
// Framed streaming XOR checksum engine. Words arrive over a valid/ready
// handshake and are XOR-folded into a running accumulator. On the last word
// of a frame the folded checksum, its parity, the saturating word count and
// an overflow flag are captured into output registers and held until the
// downstream consumer accepts them.
module xor_stream_checksum #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 16,
  parameter  int ODD       = 0,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_checksum,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  localparam logic         P_ODD     = (ODD != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] P_MAX    = CW'(MAX_WORDS);
  localparam logic [CW-1:0] P_ONE    = CW'(1);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  // Parity of a checksum word, inverted for odd-parity builds.
  function automatic logic f_parity(input logic [WIDTH-1:0] d);
    return (^d) ^ P_ODD;
  endfunction

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic [WIDTH-1:0] r_out_checksum;
  logic             r_out_parity;
  logic [CW-1:0]    r_out_count;
  logic             r_out_overflow;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_acc_next;
  logic [CW-1:0]    w_count_next;
  logic             w_ovf_next;
  logic [WIDTH-1:0] w_out_checksum_next;
  logic             w_out_parity_next;
  logic [CW-1:0]    w_out_count_next;
  logic             w_out_overflow_next;
  logic             w_out_valid_next;

  logic             w_accept;
  logic             w_first;
  logic             w_at_max;
  logic [WIDTH-1:0] w_fold;
  logic [CW-1:0]    w_count_upd;
  logic             w_ovf_upd;

  // in_ready depends on the state register only, never on in_valid.
  assign in_ready = (r_state == S_COLLECT);
  assign w_accept = in_valid && in_ready;

  // Fold and saturating-count values a word accepted this cycle would produce.
  always_comb begin
    w_first     = (r_count == '0);
    w_at_max    = (r_count == P_MAX);
    w_fold      = r_acc ^ in_data;
    w_count_upd = r_count;
    w_ovf_upd   = r_ovf;
    if (w_first) begin
      w_fold      = in_data;
      w_count_upd = P_ONE;
      w_ovf_upd   = 1'b0;
    end else if (w_at_max) begin
      w_count_upd = r_count;
      w_ovf_upd   = 1'b1;
    end else begin
      w_count_upd = r_count + P_ONE;
      w_ovf_upd   = r_ovf;
    end
  end

  // Next-state and next-register decode for the COLLECT/HOLD machine.
  always_comb begin
    w_state_next        = r_state;
    w_acc_next          = r_acc;
    w_count_next        = r_count;
    w_ovf_next          = r_ovf;
    w_out_checksum_next = r_out_checksum;
    w_out_parity_next   = r_out_parity;
    w_out_count_next    = r_out_count;
    w_out_overflow_next = r_out_overflow;
    w_out_valid_next    = r_out_valid;
    case (r_state)
      S_COLLECT: begin
        if (w_accept) begin
          w_acc_next   = w_fold;
          w_count_next = w_count_upd;
          w_ovf_next   = w_ovf_upd;
          if (in_last) begin
            // Final fold goes straight to the result registers.
            w_out_checksum_next = w_fold;
            w_out_parity_next   = f_parity(w_fold);
            w_out_count_next    = w_count_upd;
            w_out_overflow_next = w_ovf_upd;
            w_out_valid_next    = 1'b1;
            w_state_next        = S_HOLD;
          end else begin
            w_state_next = S_COLLECT;
          end
        end else begin
          w_state_next = S_COLLECT;
        end
      end
      S_HOLD: begin
        if (r_out_valid && out_ready) begin
          // Result consumed: start the next frame from a clean accumulator.
          w_out_valid_next = 1'b0;
          w_acc_next       = '0;
          w_count_next     = '0;
          w_ovf_next       = 1'b0;
          w_state_next     = S_COLLECT;
        end else begin
          w_state_next = S_HOLD;
        end
      end
      default: begin
        w_out_valid_next = 1'b0;
        w_acc_next       = '0;
        w_count_next     = '0;
        w_ovf_next       = 1'b0;
        w_state_next     = S_COLLECT;
      end
    endcase
  end

  // State register; reset discards any partial or pending frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Accumulator, count and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc          <= '0;
      r_count        <= '0;
      r_ovf          <= 1'b0;
      r_out_checksum <= '0;
      r_out_parity   <= P_ODD;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
      r_out_valid    <= 1'b0;
    end else begin
      r_acc          <= w_acc_next;
      r_count        <= w_count_next;
      r_ovf          <= w_ovf_next;
      r_out_checksum <= w_out_checksum_next;
      r_out_parity   <= w_out_parity_next;
      r_out_count    <= w_out_count_next;
      r_out_overflow <= w_out_overflow_next;
      r_out_valid    <= w_out_valid_next;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_checksum = r_out_checksum;
  assign out_parity   = r_out_parity;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_overflow;

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Self-checking bench for xor_stream_checksum: an even-parity and an
// odd-parity instance share all inputs. Directed table frames, hand-written
// timing sequences, and randomized frames checked against a frame-level model.
module tb_xor_stream_checksum;

  localparam int W   = 8;
  localparam int MAX = 16;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic [W-1:0]  in_data;
  logic          out_ready = 1'b0;
  int            ready_mode = 0;   // 0 low, 1 high, 2 random

  logic          in_ready_e, out_valid_e, par_e, ovf_e;
  logic [W-1:0]  cs_e;
  logic [CW-1:0] cnt_e;
  logic          in_ready_o, out_valid_o, par_o, ovf_o;
  logic [W-1:0]  cs_o;
  logic [CW-1:0] cnt_o;

  xor_stream_checksum #(.WIDTH(W), .MAX_WORDS(MAX), .ODD(0)) u_even (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_e),
    .out_ready(out_ready), .out_checksum(cs_e), .out_parity(par_e),
    .out_count(cnt_e), .out_overflow(ovf_e));

  xor_stream_checksum #(.WIDTH(W), .MAX_WORDS(MAX), .ODD(1)) u_odd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_o),
    .out_ready(out_ready), .out_checksum(cs_o), .out_parity(par_o),
    .out_count(cnt_o), .out_overflow(ovf_o));

  // Free-running clock.
  always #5 clk = ~clk;

  // Consumer ready, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  typedef struct {
    logic [W-1:0]  cs;
    logic          pe;
    logic          po;
    logic [CW-1:0] cnt;
    logic          ovf;
  } res_t;

  res_t res_arr[256];
  int   res_wr = 0;
  int   res_rd = 0;

  // Record every result at the negedge before the edge that consumes it.
  always @(negedge clk) begin
    if (!rst && out_valid_e && out_ready && res_wr < 256) begin
      res_arr[res_wr] = '{cs_e, par_e, par_o, cnt_e, ovf_e};
      res_wr = res_wr + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was taken.
  task automatic send_word(input logic [W-1:0] d, input logic l);
    int  budget;
    bit  done;
    budget   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!done) begin
      @(negedge clk);
      if (in_ready_e) begin
        done = 1'b1;
      end else begin
        budget++;
        if (budget > 300) begin
          check("send_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(output res_t r);
    int b;
    b = 0;
    while (res_wr <= res_rd && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (res_wr <= res_rd) begin
      check("result_timeout", 32'd0, 32'd1);
      r = '{8'h00, 1'b0, 1'b0, 5'd0, 1'b0};
    end else begin
      r = res_arr[res_rd];
      res_rd++;
    end
  endtask

  task automatic check_res(input string tag, input res_t r, input logic [W-1:0] cs,
                           input logic pe, input logic po, input logic [CW-1:0] cnt,
                           input logic ovf);
    check({tag, "_checksum"}, 32'(r.cs), 32'(cs));
    check({tag, "_parity_even"}, 32'(r.pe), 32'(pe));
    check({tag, "_parity_odd"}, 32'(r.po), 32'(po));
    check({tag, "_count"}, 32'(r.cnt), 32'(cnt));
    check({tag, "_overflow"}, 32'(r.ovf), 32'(ovf));
  endtask

  typedef struct {
    logic [159:0]  words;
    int            len;
    logic [W-1:0]  cs;
    logic          pe;
    logic          po;
    logic [CW-1:0] cnt;
    logic          ovf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    res_t         r;
    logic [W-1:0] exp_cs;
    int           len;
    logic [W-1:0] w;
    int           saved_wr;
    res_t         exp_q[$];

    tbl[0] = '{160'h07,                  1, 8'h07, 1'b1, 1'b0, 5'd1,  1'b0};
    tbl[1] = '{160'h55AAF00F,            4, 8'h00, 1'b0, 1'b1, 5'd4,  1'b0};
    tbl[2] = '{160'({17{8'h01}}),        17, 8'h01, 1'b1, 1'b0, 5'd16, 1'b1};
    tbl[3] = '{160'h02,                  1, 8'h02, 1'b1, 1'b0, 5'd1,  1'b0};
    tbl[4] = '{160'({16{8'h80}}),        16, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0};
    tbl[5] = '{160'h01FF,                2, 8'hFE, 1'b1, 1'b0, 5'd2,  1'b0};
    tbl[6] = '{160'h03,                  1, 8'h03, 1'b0, 1'b1, 5'd1,  1'b0};
    tbl[7] = '{160'h01,                  1, 8'h01, 1'b1, 1'b0, 5'd1,  1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready_e), 32'd1);
    check("rst_out_valid", 32'(out_valid_e), 32'd0);
    check("rst_checksum", 32'(cs_e), 32'd0);
    check("rst_parity_even", 32'(par_e), 32'd0);
    check("rst_parity_odd", 32'(par_o), 32'd1);
    check("rst_count", 32'(cnt_e), 32'd0);
    check("rst_overflow", 32'(ovf_e), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 1;
    @(posedge clk); #1;

    // Single word latency: valid for exactly one cycle with out_ready high.
    send_word(8'h07, 1'b1);
    @(negedge clk);
    check("lat_out_valid_rise", 32'(out_valid_e), 32'd1);
    check("lat_in_ready_hold", 32'(in_ready_e), 32'd0);
    check("lat_checksum", 32'(cs_e), 32'h07);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_out_valid_fall", 32'(out_valid_e), 32'd0);
    check("lat_in_ready_back", 32'(in_ready_e), 32'd1);
    get_result(r);
    check_res("lat", r, 8'h07, 1'b1, 1'b0, 5'd1, 1'b0);
    @(posedge clk); #1;

    // Table-driven frames with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < tbl[i].len; k++) begin
        w = tbl[i].words[8*k +: 8];
        send_word(w, (k == tbl[i].len - 1));
      end
      get_result(r);
      check_res($sformatf("tbl%0d", i), r, tbl[i].cs, tbl[i].pe, tbl[i].po,
                tbl[i].cnt, tbl[i].ovf);
      @(posedge clk); #1;
    end

    // Backpressure: result held stable for 5 cycles with out_ready low.
    ready_mode = 0;
    @(posedge clk); #1;
    send_word(8'h0F, 1'b0);
    send_word(8'hF0, 1'b0);
    send_word(8'hAA, 1'b0);
    send_word(8'h55, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", c), 32'(out_valid_e), 32'd1);
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready_e), 32'd0);
      check($sformatf("hold%0d_checksum", c), 32'(cs_e), 32'h00);
      check($sformatf("hold%0d_count", c), 32'(cnt_e), 32'd4);
      check($sformatf("hold%0d_parity", c), 32'(par_e), 32'd0);
      if (c != 4) begin
        @(posedge clk); #1;
      end
    end
    ready_mode = 1;
    @(negedge clk);
    check("hold_release_still_valid", 32'(out_valid_e), 32'd1);
    @(negedge clk);
    check("hold_release_valid", 32'(out_valid_e), 32'd0);
    check("hold_release_in_ready", 32'(in_ready_e), 32'd1);
    get_result(r);
    check_res("hold", r, 8'h00, 1'b0, 1'b1, 5'd4, 1'b0);
    @(posedge clk); #1;

    // Reset mid-frame: the partial frame never produces a result.
    saved_wr = res_wr;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready_e), 32'd1);
    check("midrst_out_valid", 32'(out_valid_e), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_result", 32'(res_wr), 32'(saved_wr));
    send_word(8'h3C, 1'b1);
    get_result(r);
    check_res("midrst", r, 8'h3C, 1'b0, 1'b1, 5'd1, 1'b0);
    @(posedge clk); #1;

    // Randomized frames, gaps and backpressure against a frame-level model.
    ready_mode = 2;
    for (int f = 0; f < 30; f++) begin
      len    = $urandom_range(1, 20);
      exp_cs = 8'h00;
      for (int k = 0; k < len; k++) begin
        w      = 8'($urandom_range(0, 255));
        exp_cs = exp_cs ^ w;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send_word(w, (k == len - 1));
      end
      exp_q.push_back('{exp_cs, ^exp_cs, ~(^exp_cs),
                        CW'((len > MAX) ? MAX : len), (len > MAX)});
    end
    for (int f = 0; f < 30; f++) begin
      get_result(r);
      check_res($sformatf("rnd%0d", f), r, exp_q[f].cs, exp_q[f].pe, exp_q[f].po,
                exp_q[f].cnt, exp_q[f].ovf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_stream_checksum.md
# xor_stream_checksum

Parametrised streaming XOR checksum engine, the sequential successor to the team's two-input XOR gate. It accepts a framed stream of WIDTH-bit words over a valid/ready handshake and XOR-folds every word of a frame into a running accumulator. At end of frame it presents the folded checksum, a configurable even/odd parity bit, the word count and an overflow flag, and holds them until a downstream consumer accepts them. It sits between a word source (test stimulus or upstream datapath) and any consumer needing frame integrity data.

## Interface
Parameters:
- WIDTH, 8: data word width in bits (≥1).
- MAX_WORDS, 16: maximum counted words per frame (≥1).
- ODD, 0: 0 = even parity, 1 = odd parity on out_parity.
- CW (localparam), $clog2(MAX_WORDS+1): count width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  word is the last of its frame.
- out_valid  output  1  frame result is valid.
- out_ready  input  1  consumer accepts the result.
- out_checksum  output  WIDTH  XOR of all words in the frame.
- out_parity  output  1  (^out_checksum) ^ ODD.
- out_count  output  CW  words accepted in the frame, saturating at MAX_WORDS.
- out_overflow  output  1  frame exceeded MAX_WORDS words.

## Operation
- Two states: COLLECT (reset state) and HOLD.
- in_ready = 1 in COLLECT, 0 in HOLD; it is decoded combinationally from the state register only and never depends on in_valid.
- Accept = in_valid && in_ready.
- COLLECT, accept, first word of frame (count == 0): acc <= in_data; count <= 1.
- COLLECT, accept, subsequent word: acc <= acc ^ in_data; if count == MAX_WORDS then count stays and ovf <= 1, else count <= count + 1.
- COLLECT, accept with in_last: the final fold and count update are written directly into the out_* registers, out_valid <= 1, state -> HOLD.
- HOLD: out_checksum, out_parity, out_count, out_overflow and out_valid stay stable. When out_valid && out_ready, out_valid <= 0, acc/count/ovf are cleared to 0 and state -> COLLECT.
- A frame always contains at least one word; there is no empty-frame case.
- in_valid is ignored in HOLD. The upstream holds its word, since in_ready is 0.
- out_parity is computed from the final checksum. It is 1 when the checksum has an odd number of ones (ODD=0), or inverted from that when ODD=1.

## Timing
- Reset (asynchronous assert, released synchronously to clk by the system): state = COLLECT, in_ready = 1, out_valid = 0, out_checksum = 0, out_parity = ODD, out_count = 0, out_overflow = 0, acc = 0, count = 0, ovf = 0.
- Latency: out_valid rises on the edge that accepts the in_last word, so it is visible in the following cycle.
- Throughput: one word per cycle within a frame. Each frame costs at least one HOLD cycle in which in_ready = 0, so back-to-back single-word frames run at 1 word per 2 cycles.
- If out_ready is already high when out_valid rises, the result is consumed after exactly one cycle and in_ready returns to 1 the next cycle.
- Reset mid-frame or during HOLD discards the partial or pending frame with no output.
- The count saturates at MAX_WORDS and never wraps. Once out_overflow is set it stays set until that frame's result is consumed.

## Test plan
- Single word 0x07 with in_last, out_ready = 1 (WIDTH=8, ODD=0) -> out_valid for one cycle with checksum 0x07, parity 1, count 1, overflow 0.
- Frame 0x0F, 0xF0, 0xAA, 0x55 (last) on consecutive cycles -> checksum 0x00, parity 0, count 4, overflow 0. The result appears one cycle after the last word.
- Same frame with out_ready held 0 for 5 cycles -> out_* stable and in_ready = 0 for all 5 cycles. One cycle after out_ready = 1, out_valid = 0 and in_ready = 1.
- MAX_WORDS=16, 17 words of 0x01 -> checksum 0x01, count 16, overflow 1. The next frame (single 0x02) -> count 1, overflow 0.
- Reset asserted after 2 words of a frame, then frame 0x3C (last) -> checksum 0x3C, count 1. No result is ever emitted for the aborted frame.
- ODD=1 build, frame 0x03 (last) -> parity 1. Frame 0x01 (last) -> parity 0. Reset value of out_parity is 1.
